// File: rtl/jtag_pkg.sv
// jtag_pkg: shared state encoding and sizing constants for the JTAG shift master
package jtag_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} jtag_state_e;
  localparam int JTAG_MAX_BITS = 32;
  localparam int JTAG_CNT_W = 6;
endpackage

// File: rtl/jtag_tdo_sync.sv
// jtag_tdo_sync: two-flop synchronizer bringing TDO into the internal_clk domain
module jtag_tdo_sync (
  input  logic internal_clk,
  input  logic reset,
  input  logic tdo,
  output logic tdo_s
);
  logic meta;
  always_ff @(posedge internal_clk or posedge reset)
    if (reset) {tdo_s, meta} <= '0;
    else {tdo_s, meta} <= {meta, tdo};
endmodule

// File: rtl/jtag_shift_master.sv
// jtag_shift_master: drives TCK/TMS/TDI for up to MAX_BITS bit pairs, LSB first, and captures TDO
module jtag_shift_master
  import jtag_pkg::*;
#(
  parameter int HALF_PERIOD = 6,
  parameter int MAX_BITS = JTAG_MAX_BITS
) (
  input  logic                  internal_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [JTAG_CNT_W-1:0] bit_count,
  input  logic [MAX_BITS-1:0]   tms_vec,
  input  logic [MAX_BITS-1:0]   tdi_vec,
  output logic                  ready,
  output logic                  done,
  output logic [MAX_BITS-1:0]   tdo_vec,
  output logic                  tck,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo
);
  localparam int CW = $clog2(HALF_PERIOD + 1);
  localparam int IW = $clog2(MAX_BITS);
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);
  jtag_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d, nxt;
  logic [JTAG_CNT_W-1:0] n_lat, n_lat_d;
  logic [MAX_BITS-1:0] tms_lat, tms_lat_d, tdi_lat, tdi_lat_d, tdo_vec_d;
  logic tck_d, tms_d, tdi_d, done_d, tdo_s, go, bad_req, pe, last, adv;
  jtag_tdo_sync u_sync (.internal_clk(internal_clk), .reset(reset), .tdo(tdo), .tdo_s(tdo_s));
  assign ready = state == IDLE;
  assign go = ready && start && bit_count != '0 && bit_count <= JTAG_CNT_W'(MAX_BITS);
  assign bad_req = ready && start && !go;
  assign pe = cnt == '0;
  assign last = JTAG_CNT_W'(idx) == n_lat - JTAG_CNT_W'(1);
  assign nxt = idx + IW'(1);
  assign adv = state == HIGH && pe && !last;
  always_ff @(posedge internal_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      n_lat <= '0;
      tms_lat <= '0;
      tdi_lat <= '0;
      tdo_vec <= '0;
      tck <= 1'b0;
      tms <= 1'b1;
      tdi <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      n_lat <= n_lat_d;
      tms_lat <= tms_lat_d;
      tdi_lat <= tdi_lat_d;
      tdo_vec <= tdo_vec_d;
      tck <= tck_d;
      tms <= tms_d;
      tdi <= tdi_d;
      done <= done_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = go ? LOW : IDLE;
      LOW:     state_d = pe ? HIGH : LOW;
      HIGH:    state_d = pe ? (last ? FINISH : LOW) : HIGH;
      default: state_d = IDLE;
    endcase
  end
  // the phase counter reloads on every state change so each TCK half lasts exactly HALF_PERIOD cycles
  always_comb begin
    cnt_d = (state_d != state) ? RELOAD : (state == IDLE) ? cnt : cnt - CW'(1);
    idx_d = go ? '0 : adv ? nxt : idx;
    n_lat_d = go ? bit_count : n_lat;
    tms_lat_d = go ? tms_vec : tms_lat;
    tdi_lat_d = go ? tdi_vec : tdi_lat;
    tck_d = (state == LOW && pe) ? 1'b1 : (state == HIGH && pe) ? 1'b0 : tck;
    tms_d = go ? tms_vec[0] : adv ? tms_lat[nxt] : tms;
    tdi_d = go ? tdi_vec[0] : adv ? tdi_lat[nxt] : tdi;
    done_d = bad_req || (state == HIGH && pe && last);
    tdo_vec_d = go ? '0 : tdo_vec;
    if (state == LOW && pe) tdo_vec_d[idx] = tdo_s;
  end
endmodule
